mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- XLEN, 64, data/address width (from sysconfig)
- WDOG_MAX, 255, bus-wait cycle limit before abort
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- if_req_valid_i  in  1  fetch request
- if_addr_i  in  XLEN  fetch address
- if_kill_i  in  1  discard in-flight fetch (pipeline flush)
- if_rdata_o  out  32  fetched instruction
- if_rdata_valid_o  out  1  fetch data valid, one-cycle pulse
- ram_stall_valid_if_o  out  1  fetch stall request to clint
- mem_req_valid_i  in  1  load/store request
- mem_we_i  in  1  1=store
- mem_addr_i  in  XLEN  load/store address
- mem_wdata_i  in  XLEN  store data
- mem_wmask_i  in  8  store byte mask
- mem_rdata_o  out  XLEN  load data
- mem_rdata_valid_o  out  1  load/store complete, one-cycle pulse
- ram_stall_valid_mem_o  out  1  mem stall request to clint
- bus_req_valid_o  out  1  downstream request valid
- bus_req_ready_i  in  1  downstream accepts request
- bus_we_o, bus_addr_o, bus_wdata_o, bus_wmask_o  out  1/XLEN/XLEN/8  latched request fields
- bus_resp_valid_i  in  1  downstream response
- bus_rdata_i  in  XLEN  response data
- bus_err_o  out  1  watchdog abort, one-cycle pulse

Function
REQ-003 FSM states SHALL be IDLE, REQ, WAIT, DONE; owner register SHALL be IF or MEM.
REQ-004 IDLE: mem_req_valid_i SHALL win over if_req_valid_i; on grant, latch owner/addr/we/wdata/wmask (IF forces we=0, wmask=0), go to REQ next cycle.
REQ-005 REQ: bus_req_valid_o=1 with latched fields held stable; on bus_req_ready_i go to WAIT.
REQ-006 WAIT: on bus_resp_valid_i latch bus_rdata_i, go to DONE.
REQ-007 DONE: assert owner's rdata_valid pulse for exactly one cycle, then IDLE; no new grant in DONE.
REQ-008 if_rdata_o SHALL be bus_rdata bits [31:0] when if_addr[2]=0, else [63:32]; mem_rdata_o full XLEN, zero for stores.
REQ-009 ram_stall_valid_X_o SHALL be X_req_valid_i AND NOT (state==DONE AND owner==X), combinational.
REQ-010 Minimum request-to-data latency SHALL be 3 cycles (grant, REQ with ready, response same cycle as WAIT entry+0, DONE).
REQ-011 if_kill_i with owner=IF: in REQ, abort to IDLE without bus handshake; in WAIT, complete bus transaction but suppress if_rdata_valid_o; kill SHALL never affect MEM ownership.
REQ-012 Kill latched in WAIT SHALL persist until DONE even if if_kill_i deasserts.
REQ-013 Watchdog counter SHALL clear on entering REQ, increment each cycle in REQ/WAIT, saturate at WDOG_MAX; reaching WDOG_MAX SHALL pulse bus_err_o, force IDLE, emit no rdata_valid.
REQ-014 A requester dropping valid while owning the bus SHALL NOT abort the transaction (except via REQ-011).
REQ-015 Simultaneous IF and MEM requests in IDLE SHALL serve MEM first; IF served on next IDLE.

Reset
REQ-016 rst_n low SHALL immediately force state IDLE, owner IF, watchdog 0, latched fields 0.
REQ-017 During reset all outputs SHALL be 0 except stall outputs, which follow REQ-009 (owner not DONE).
REQ-018 Reset mid-transaction SHALL drop it; responses arriving after reset release in IDLE SHALL be ignored.

Verification
REQ-019 Fetch: if_req addr 0x8000_0004, ready=1, response next cycle data 0x1234_5678_9ABC_DEF0 -> if_rdata_o=0x1234_5678, pulse 3 cycles after grant, stall low in DONE.
REQ-020 Contention: both requests same cycle, MEM store addr 0x8000_1000 wdata 0xAA mask 0x01 -> bus sees store first, then IF read; IF stall held throughout.
REQ-021 Kill: IF in WAIT, if_kill_i pulse 1 cycle -> response consumed, if_rdata_valid_o stays 0, return IDLE.
REQ-022 Watchdog: ready=1, bus_resp_valid_i never -> bus_err_o pulse after 255 cycles, FSM IDLE, next request granted.
REQ-023 Backpressure: bus_req_ready_i low 5 cycles -> bus fields stable all 5 cycles, single handshake.
REQ-024 Reset: rst_n low in WAIT -> next edge state IDLE, bus_req_valid_o=0, later response ignored.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Port bundle for mem_arbiter: fetch port, load/store port, downstream bus and debug state.
// Handshake: a bus request transfers on a cycle where bus_req_valid_o && bus_req_ready_i; responses are single-cycle bus_resp_valid_i strobes.
interface mem_arbiter_if #(
  parameter int XLEN = 64
);
  logic            if_req_valid_i;
  logic [XLEN-1:0] if_addr_i;
  logic            if_kill_i;
  logic [31:0]     if_rdata_o;
  logic            if_rdata_valid_o;
  logic            ram_stall_valid_if_o;

  logic            mem_req_valid_i;
  logic            mem_we_i;
  logic [XLEN-1:0] mem_addr_i;
  logic [XLEN-1:0] mem_wdata_i;
  logic [7:0]      mem_wmask_i;
  logic [XLEN-1:0] mem_rdata_o;
  logic            mem_rdata_valid_o;
  logic            ram_stall_valid_mem_o;

  logic            bus_req_valid_o;
  logic            bus_req_ready_i;
  logic            bus_we_o;
  logic [XLEN-1:0] bus_addr_o;
  logic [XLEN-1:0] bus_wdata_o;
  logic [7:0]      bus_wmask_o;
  logic            bus_resp_valid_i;
  logic [XLEN-1:0] bus_rdata_i;
  logic            bus_err_o;

  // Debug view of the arbiter FSM: 0=IDLE 1=REQ 2=WAIT 3=DONE
  logic [1:0]      dbg_state;

  modport slave (
    input  if_req_valid_i, if_addr_i, if_kill_i,
    output if_rdata_o, if_rdata_valid_o, ram_stall_valid_if_o,
    input  mem_req_valid_i, mem_we_i, mem_addr_i, mem_wdata_i, mem_wmask_i,
    output mem_rdata_o, mem_rdata_valid_o, ram_stall_valid_mem_o,
    output bus_req_valid_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_wmask_o, bus_err_o,
    input  bus_req_ready_i, bus_resp_valid_i, bus_rdata_i,
    output dbg_state
  );

  modport master (
    output if_req_valid_i, if_addr_i, if_kill_i,
    input  if_rdata_o, if_rdata_valid_o, ram_stall_valid_if_o,
    output mem_req_valid_i, mem_we_i, mem_addr_i, mem_wdata_i, mem_wmask_i,
    input  mem_rdata_o, mem_rdata_valid_o, ram_stall_valid_mem_o,
    input  bus_req_valid_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_wmask_o, bus_err_o,
    output bus_req_ready_i, bus_resp_valid_i, bus_rdata_i,
    input  dbg_state
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (fetch / load-store) arbiter onto a single downstream bus, one transaction at a time,
// with fetch kill, bus watchdog and load-store priority.
module mem_arbiter #(
  parameter int XLEN     = 64,
  parameter int WDOG_MAX = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  arb
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_t;

  localparam int            WW        = $clog2(WDOG_MAX + 1);
  localparam logic [WW-1:0] WDOG_TOP  = WW'(WDOG_MAX);
  localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_MAX - 1);

  state_t          state_q;
  owner_t          owner_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] rdata_q;
  logic            we_q;
  logic [7:0]      wmask_q;
  logic            kill_q;
  logic [WW-1:0]   wdog_q;
  logic            err_q;

  logic            kill_now;
  logic            wdog_hit;
  logic [WW-1:0]   wdog_inc;

  // Kill only ever applies to a fetch that owns the bus.
  assign kill_now = (owner_q == OWN_IF) && arb.if_kill_i;
  assign wdog_hit = (wdog_q >= WDOG_LAST);
  assign wdog_inc = (wdog_q == WDOG_TOP) ? wdog_q : wdog_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= OWN_IF;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      wmask_q <= '0;
      kill_q  <= 1'b0;
      wdog_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (arb.mem_req_valid_i) begin
            owner_q <= OWN_MEM;
            addr_q  <= arb.mem_addr_i;
            we_q    <= arb.mem_we_i;
            wdata_q <= arb.mem_wdata_i;
            wmask_q <= arb.mem_wmask_i;
            kill_q  <= 1'b0;
            wdog_q  <= '0;
            state_q <= REQ;
          end else if (arb.if_req_valid_i) begin
            owner_q <= OWN_IF;
            addr_q  <= arb.if_addr_i;
            we_q    <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
            kill_q  <= 1'b0;
            wdog_q  <= '0;
            state_q <= REQ;
          end
        end
        REQ: begin
          if (kill_now) begin
            state_q <= IDLE;
          end else if (arb.bus_req_ready_i) begin
            wdog_q  <= wdog_inc;
            state_q <= WAIT;
          end else if (wdog_hit) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            wdog_q  <= wdog_inc;
          end
        end
        WAIT: begin
          // Once accepted, a killed fetch still drains its response; remember the kill until DONE.
          kill_q <= kill_q | kill_now;
          if (arb.bus_resp_valid_i) begin
            rdata_q <= arb.bus_rdata_i;
            state_q <= DONE;
          end else if (wdog_hit) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            wdog_q  <= wdog_inc;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign arb.bus_req_valid_o  = (state_q == REQ) && !kill_now;
  assign arb.bus_we_o         = we_q;
  assign arb.bus_addr_o       = addr_q;
  assign arb.bus_wdata_o      = wdata_q;
  assign arb.bus_wmask_o      = wmask_q;
  assign arb.bus_err_o        = err_q;

  assign arb.if_rdata_valid_o  = (state_q == DONE) && (owner_q == OWN_IF) && !kill_q;
  assign arb.mem_rdata_valid_o = (state_q == DONE) && (owner_q == OWN_MEM);
  assign arb.if_rdata_o        = addr_q[2] ? rdata_q[63:32] : rdata_q[31:0];
  assign arb.mem_rdata_o       = we_q ? '0 : rdata_q;

  // Stall releases exactly in the cycle the requester's data is delivered.
  assign arb.ram_stall_valid_if_o  = arb.if_req_valid_i &&
                                     !((state_q == DONE) && (owner_q == OWN_IF));
  assign arb.ram_stall_valid_mem_o = arb.mem_req_valid_i &&
                                     !((state_q == DONE) && (owner_q == OWN_MEM));

  assign arb.dbg_state = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized bench for mem_arbiter; a transaction-level model predicts bus fields,
// delivery cycle and returned data, and a scoreboard queue holds the expected read data.
module tb_mem_arbiter;
  localparam int XLEN = 64;
  localparam int WDOG = 255;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.XLEN(XLEN)) arb ();

  mem_arbiter #(.XLEN(XLEN), .WDOG_MAX(WDOG)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .arb   (arb)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [XLEN-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_check(input string tag, input logic [63:0] obs);
    chk({tag, "_depth"}, 64'(exp_q.size()), 64'd1);
    if (exp_q.size() != 0) chk(tag, obs, exp_q.pop_front());
  endtask

  // One complete transaction from an IDLE cycle; the requester holds valid until its data arrives.
  task automatic run_txn(input bit is_mem, input logic [63:0] addr, input bit we,
                         input logic [63:0] wdata, input logic [7:0] wmask,
                         input int rdy_dly, input int rsp_dly, input logic [63:0] rsp,
                         input bit other_wait);
    if (is_mem) exp_q.push_back(we ? 64'd0 : rsp);
    else        exp_q.push_back(addr[2] ? {32'd0, rsp[63:32]} : {32'd0, rsp[31:0]});
    if (is_mem) begin
      arb.mem_req_valid_i = 1'b1;
      arb.mem_we_i        = we;
      arb.mem_addr_i      = addr;
      arb.mem_wdata_i     = wdata;
      arb.mem_wmask_i     = wmask;
    end else begin
      arb.if_req_valid_i  = 1'b1;
      arb.if_addr_i       = addr;
    end
    #1;
    chk("grant_stall", is_mem ? arb.ram_stall_valid_mem_o : arb.ram_stall_valid_if_o, 1);
    chk("grant_busvalid", arb.bus_req_valid_o, 0);
    if (other_wait) chk("grant_other_stall", arb.ram_stall_valid_if_o, 1);
    step();
    if (is_mem) begin
      arb.mem_we_i    = ~we;
      arb.mem_addr_i  = ~addr;
      arb.mem_wdata_i = ~wdata;
      arb.mem_wmask_i = ~wmask;
    end
    for (int i = 0; i <= rdy_dly; i++) begin
      arb.bus_req_ready_i = (i == rdy_dly);
      #1;
      chk("req_valid", arb.bus_req_valid_o, 1);
      chk("req_addr", arb.bus_addr_o, addr);
      chk("req_we", arb.bus_we_o, is_mem ? we : 1'b0);
      chk("req_wmask", arb.bus_wmask_o, is_mem ? wmask : 8'd0);
      if (is_mem) chk("req_wdata", arb.bus_wdata_o, wdata);
      step();
    end
    arb.bus_req_ready_i = 1'b0;
    for (int j = 0; j <= rsp_dly; j++) begin
      arb.bus_resp_valid_i = (j == rsp_dly);
      arb.bus_rdata_i      = (j == rsp_dly) ? rsp : {$urandom, $urandom};
      #1;
      chk("wait_busvalid", arb.bus_req_valid_o, 0);
      chk("wait_pulse", arb.if_rdata_valid_o | arb.mem_rdata_valid_o, 0);
      step();
    end
    arb.bus_resp_valid_i = 1'b0;
    chk("done_pulse", is_mem ? arb.mem_rdata_valid_o : arb.if_rdata_valid_o, 1);
    chk("done_other_pulse", is_mem ? arb.if_rdata_valid_o : arb.mem_rdata_valid_o, 0);
    chk("done_stall", is_mem ? arb.ram_stall_valid_mem_o : arb.ram_stall_valid_if_o, 0);
    if (other_wait) chk("done_other_stall", arb.ram_stall_valid_if_o, 1);
    sb_check("done_rdata", is_mem ? arb.mem_rdata_o : {32'd0, arb.if_rdata_o});
    if (is_mem) arb.mem_req_valid_i = 1'b0;
    else        arb.if_req_valid_i  = 1'b0;
    step();
    chk("idle_pulse", arb.if_rdata_valid_o | arb.mem_rdata_valid_o, 0);
  endtask

  initial begin
    int early;
    int mode;
    logic [63:0] a;
    logic [63:0] d;

    arb.if_req_valid_i   = 1'b1;
    arb.if_addr_i        = '0;
    arb.if_kill_i        = 1'b0;
    arb.mem_req_valid_i  = 1'b0;
    arb.mem_we_i         = 1'b0;
    arb.mem_addr_i       = '0;
    arb.mem_wdata_i      = '0;
    arb.mem_wmask_i      = '0;
    arb.bus_req_ready_i  = 1'b0;
    arb.bus_resp_valid_i = 1'b0;
    arb.bus_rdata_i      = '0;

    // reset values, fetch request pending while in reset
    step();
    step();
    chk("rst_state", arb.dbg_state, ST_IDLE);
    chk("rst_busvalid", arb.bus_req_valid_o, 0);
    chk("rst_bus_fields", {arb.bus_we_o, arb.bus_wmask_o} | arb.bus_addr_o | arb.bus_wdata_o, 0);
    chk("rst_rdata", arb.mem_rdata_o | {32'd0, arb.if_rdata_o}, 0);
    chk("rst_pulses", {arb.if_rdata_valid_o, arb.mem_rdata_valid_o, arb.bus_err_o}, 0);
    chk("rst_if_stall", arb.ram_stall_valid_if_o, 1);
    chk("rst_mem_stall", arb.ram_stall_valid_mem_o, 0);
    arb.if_req_valid_i = 1'b0;
    rst_n = 1'b1;
    step();

    // fetch: upper and lower word selection
    run_txn(0, 64'h8000_0004, 0, 0, 0, 0, 0, 64'h1234_5678_9ABC_DEF0, 0);
    run_txn(0, 64'h8000_0000, 0, 0, 0, 0, 0, 64'h1234_5678_9ABC_DEF0, 0);

    // contention: store wins, fetch waits with stall held, then is served
    arb.if_req_valid_i = 1'b1;
    arb.if_addr_i      = 64'h8000_2000;
    run_txn(1, 64'h8000_1000, 1, 64'hAA, 8'h01, 0, 0, 64'hDEAD_BEEF_0000_1111, 1);
    run_txn(0, 64'h8000_2000, 0, 0, 0, 0, 0, 64'h0BAD_F00D_CAFE_0001, 0);

    // backpressure: ready low 5 cycles, fields held, then a load
    run_txn(1, 64'h8000_3008, 0, 64'h5555, 8'hFF, 5, 1, 64'hFEED_FACE_0123_4567, 0);

    // kill held during a load/store transaction must not disturb it
    arb.if_kill_i = 1'b1;
    run_txn(1, 64'h8000_4000, 0, 0, 0, 1, 1, 64'h1111_2222_3333_4444, 0);
    arb.if_kill_i = 1'b0;

    // kill in REQ: abort without handshake
    arb.if_req_valid_i = 1'b1;
    arb.if_addr_i      = 64'h8000_5000;
    step();
    arb.if_kill_i       = 1'b1;
    arb.if_req_valid_i  = 1'b0;
    arb.bus_req_ready_i = 1'b1;
    #1;
    chk("kreq_busvalid", arb.bus_req_valid_o, 0);
    step();
    arb.if_kill_i       = 1'b0;
    arb.bus_req_ready_i = 1'b0;
    chk("kreq_state", arb.dbg_state, ST_IDLE);
    step();
    chk("kreq_idle_busvalid", arb.bus_req_valid_o, 0);

    // kill in WAIT: response drained, no fetch pulse
    arb.if_req_valid_i = 1'b1;
    arb.if_addr_i      = 64'h8000_6000;
    step();
    arb.bus_req_ready_i = 1'b1;
    step();
    arb.bus_req_ready_i = 1'b0;
    arb.if_kill_i       = 1'b1;
    arb.if_req_valid_i  = 1'b0;
    step();
    arb.if_kill_i = 1'b0;
    chk("kwait_state", arb.dbg_state, ST_WAIT);
    step();
    arb.bus_resp_valid_i = 1'b1;
    arb.bus_rdata_i      = 64'h7777_8888_9999_AAAA;
    step();
    arb.bus_resp_valid_i = 1'b0;
    chk("kwait_done_state", arb.dbg_state, ST_DONE);
    chk("kwait_pulse", arb.if_rdata_valid_o, 0);
    step();
    chk("kwait_idle", arb.dbg_state, ST_IDLE);
    chk("kwait_idle_pulse", arb.if_rdata_valid_o, 0);

    // watchdog: accepted, never answered
    arb.if_req_valid_i = 1'b1;
    arb.if_addr_i      = 64'h8000_7000;
    step();
    arb.bus_req_ready_i = 1'b1;
    early = int'(arb.bus_err_o);
    step();
    arb.bus_req_ready_i = 1'b0;
    for (int k = 2; k <= WDOG; k++) begin
      early += int'(arb.bus_err_o) + int'(arb.if_rdata_valid_o);
      step();
    end
    chk("wdog_early", 64'(early), 0);
    chk("wdog_err", arb.bus_err_o, 1);
    chk("wdog_state", arb.dbg_state, ST_IDLE);
    chk("wdog_pulse", arb.if_rdata_valid_o, 0);
    arb.if_req_valid_i = 1'b0;
    step();
    chk("wdog_err_once", arb.bus_err_o, 0);
    run_txn(0, 64'h8000_7004, 0, 0, 0, 0, 2, 64'hABCD_0000_0000_1234, 0);

    // reset in WAIT, late response ignored
    arb.if_req_valid_i = 1'b1;
    arb.if_addr_i      = 64'h8000_8000;
    step();
    arb.bus_req_ready_i = 1'b1;
    step();
    arb.bus_req_ready_i = 1'b0;
    chk("rstw_pre", arb.dbg_state, ST_WAIT);
    rst_n = 1'b0;
    #1;
    chk("rstw_state", arb.dbg_state, ST_IDLE);
    chk("rstw_busvalid", arb.bus_req_valid_o, 0);
    chk("rstw_addr", arb.bus_addr_o, 0);
    chk("rstw_if_stall", arb.ram_stall_valid_if_o, 1);
    step();
    rst_n = 1'b1;
    arb.if_req_valid_i   = 1'b0;
    arb.bus_resp_valid_i = 1'b1;
    arb.bus_rdata_i      = 64'h1;
    step();
    arb.bus_resp_valid_i = 1'b0;
    chk("rstw_late_pulse", arb.if_rdata_valid_o | arb.mem_rdata_valid_o, 0);
    chk("rstw_late_state", arb.dbg_state, ST_IDLE);
    step();

    // randomized traffic
    for (int n = 0; n < 24; n++) begin
      mode = $urandom_range(0, 2);
      a    = {$urandom, $urandom};
      d    = {$urandom, $urandom};
      if (mode == 0) begin
        run_txn(0, a, 0, 0, 0, $urandom_range(0, 3), $urandom_range(0, 3), d, 0);
      end else if (mode == 1) begin
        run_txn(1, a, 1'($urandom), {$urandom, $urandom}, 8'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 3), d, 0);
      end else begin
        arb.if_req_valid_i = 1'b1;
        arb.if_addr_i      = ~a;
        run_txn(1, a, 1'($urandom), {$urandom, $urandom}, 8'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 3), d, 1);
        run_txn(0, ~a, 0, 0, 0, $urandom_range(0, 3), $urandom_range(0, 3), ~d, 0);
      end
    end

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
